// File: rtl/pong_frame_engine.sv
// Pong game core: a frame tick derived from the line counter advances ball, paddle and score,
// and a registered pixel path colours each x/y from the current game state.
//   state   | meaning
//   SERVE   | ball parked at serve point, counting serve frames
//   PLAY    | ball moving, walls reflect, left edge checks the paddle
//   MISS    | ball frozen, background red, counting miss frames
module pong_frame_engine #(
  parameter int PADDLE_H     = 64,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       blank,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  output logic       R,
  output logic       G,
  output logic       B,
  output logic [3:0] hits,
  output logic [3:0] misses
);

  localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [9:0] SZ      = 10'(BALL_SIZE);
  localparam logic [9:0] BS      = 10'(BALL_SPEED);
  localparam logic [9:0] PS      = 10'(PADDLE_SPEED);
  localparam logic [9:0] PH      = 10'(PADDLE_H);
  localparam logic [9:0] SERVE_X = 10'd316;
  localparam logic [9:0] SERVE_Y = 10'd236;
  localparam logic [9:0] PY_INIT = 10'd208;
  localparam logic [9:0] PY_MIN  = 10'd4;
  localparam logic [9:0] PY_MAX  = 10'(476 - PADDLE_H);
  localparam logic [9:0] TOP     = 10'd4;
  localparam logic [9:0] BOTTOM  = 10'd476;
  localparam logic [9:0] LEFT    = 10'd24;
  localparam logic [9:0] RIGHT   = 10'd636;
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] MISS_LAST  = CW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d, py_q, py_d, y_q;
  logic          dxn_q, dxn_d, dyp_q, dyp_d;
  logic [3:0]    hits_q, hits_d, misses_q, misses_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          tick_w, miss_w;
  logic          in_ball, in_pad, in_border;

  assign tick_w = (y == 10'd480) && (y_q != 10'd480);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dxn_d    = dxn_q;
    dyp_d    = dyp_q;
    py_d     = py_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    miss_w   = 1'b0;
    if (tick_w) begin
      if (BTN_UP && !BTN_DN)
        py_d = (py_q < PY_MIN + PS) ? PY_MIN : py_q - PS;
      else if (BTN_DN && !BTN_UP)
        py_d = (py_q + PS > PY_MAX) ? PY_MAX : py_q + PS;

      unique case (state_q)
        S_SERVE: begin
          bx_d  = SERVE_X;
          by_d  = SERVE_Y;
          dxn_d = 1'b1;
          dyp_d = 1'b1;
          if (cnt_q == SERVE_LAST) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PLAY: begin
          // Paddle overlap uses the pre-move paddle position.
          if (dxn_q && bx_q < LEFT + BS) begin
            if (by_q + SZ > py_q && by_q < py_q + PH) begin
              bx_d   = LEFT;
              dxn_d  = 1'b0;
              hits_d = (hits_q == 4'hF) ? hits_q : hits_q + 4'd1;
            end else begin
              miss_w = 1'b1;
            end
          end else if (!dxn_q && bx_q + SZ + BS > RIGHT) begin
            bx_d  = RIGHT - SZ;
            dxn_d = 1'b1;
          end else begin
            bx_d = dxn_q ? bx_q - BS : bx_q + BS;
          end

          if (!dyp_q && by_q < TOP + BS) begin
            by_d  = TOP;
            dyp_d = 1'b1;
          end else if (dyp_q && by_q + SZ + BS > BOTTOM) begin
            by_d  = BOTTOM - SZ;
            dyp_d = 1'b0;
          end else begin
            by_d = dyp_q ? by_q + BS : by_q - BS;
          end

          if (miss_w) begin
            bx_d     = bx_q;
            by_d     = by_q;
            dxn_d    = dxn_q;
            dyp_d    = dyp_q;
            state_d  = S_MISS;
            cnt_d    = '0;
            misses_d = (misses_q == 4'hF) ? misses_q : misses_q + 4'd1;
          end
        end
        S_MISS: begin
          if (cnt_q == MISS_LAST) begin
            state_d = S_SERVE;
            cnt_d   = '0;
            bx_d    = SERVE_X;
            by_d    = SERVE_Y;
            dxn_d   = 1'b1;
            dyp_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_SERVE;
      endcase
    end
  end

  assign in_ball   = (x >= bx_q) && (x < bx_q + SZ) && (y >= by_q) && (y < by_q + SZ);
  assign in_pad    = (x >= 10'd16) && (x <= 10'd23) && (y >= py_q) && (y < py_q + PH);
  assign in_border = (x < 10'd4) || (x > 10'd635) || (y < 10'd4) || (y > 10'd475);

  always_comb begin
    rgb_d = 3'b000;
    if (blank)                 rgb_d = 3'b000;
    else if (in_ball)          rgb_d = 3'b111;
    else if (in_pad)           rgb_d = 3'b010;
    else if (in_border)        rgb_d = 3'b001;
    else if (state_q == S_MISS) rgb_d = 3'b100;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_SERVE;
      cnt_q    <= '0;
      bx_q     <= SERVE_X;
      by_q     <= SERVE_Y;
      dxn_q    <= 1'b1;
      dyp_q    <= 1'b1;
      py_q     <= PY_INIT;
      hits_q   <= 4'd0;
      misses_q <= 4'd0;
      rgb_q    <= 3'b000;
      y_q      <= 10'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dxn_q    <= dxn_d;
      dyp_q    <= dyp_d;
      py_q     <= py_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      rgb_q    <= rgb_d;
      y_q      <= y;
    end
  end

  assign R      = rgb_q[2];
  assign G      = rgb_q[1];
  assign B      = rgb_q[0];
  assign hits   = hits_q;
  assign misses = misses_q;

endmodule

// File: tb/tb_pong_frame_engine.sv
// Directed bench for pong_frame_engine: an integer game model predicts pixel colours,
// expectations are queued at probe time and compared when the registered pixel appears.
module tb_pong_frame_engine;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [9:0] x, y;
  logic       blank, BTN_UP, BTN_DN;
  logic       R, G, B;
  logic [3:0] hits, misses;

  always #5 CLK = ~CLK;

  pong_frame_engine dut (
    .CLK(CLK), .RST_N(RST_N), .x(x), .y(y), .blank(blank),
    .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .R(R), .G(G), .B(B),
    .hits(hits), .misses(misses)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] exp;
  } exp_t;
  exp_t sbq[$];

  // Reference game state: 0 serve, 1 play, 2 miss
  int m_state, m_cnt, m_bx, m_by, m_py, m_hits, m_misses;
  bit m_dxn, m_dyp, last_hit;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_py = 208;
    m_dxn = 1; m_dyp = 1; m_hits = 0; m_misses = 0;
  endtask

  task automatic model_tick(input bit up, input bit dn, output bit hit);
    int old_py, nbx, nby;
    bit miss;
    hit = 0; miss = 0; old_py = m_py;
    if (up && !dn)      m_py = (m_py - 4 < 4) ? 4 : m_py - 4;
    else if (dn && !up) m_py = (m_py + 4 > 412) ? 412 : m_py + 4;
    if (m_state == 0) begin
      m_bx = 316; m_by = 236; m_dxn = 1; m_dyp = 1;
      m_cnt++;
      if (m_cnt == 60) begin m_state = 1; m_cnt = 0; end
    end else if (m_state == 1) begin
      if (m_dxn && m_bx < 26) begin
        if (m_by + 8 > old_py && m_by < old_py + 64) begin
          nbx = 24; m_dxn = 0; hit = 1;
          if (m_hits < 15) m_hits++;
        end else begin
          miss = 1; nbx = m_bx;
        end
      end else if (!m_dxn && m_bx + 10 > 636) begin
        nbx = 628; m_dxn = 1;
      end else begin
        nbx = m_dxn ? m_bx - 2 : m_bx + 2;
      end
      if (!m_dyp && m_by < 6)            begin nby = 4;   m_dyp = 1; end
      else if (m_dyp && m_by + 10 > 476) begin nby = 468; m_dyp = 0; end
      else nby = m_dyp ? m_by + 2 : m_by - 2;
      if (miss) begin
        m_state = 2; m_cnt = 0;
        if (m_misses < 15) m_misses++;
      end else begin
        m_bx = nbx; m_by = nby;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 30) begin
        m_state = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_dxn = 1; m_dyp = 1;
      end
    end
  endtask

  function automatic logic [2:0] model_pix(int px, int pyv, bit bl);
    if (bl) return 3'b000;
    if (px >= m_bx && px < m_bx + 8 && pyv >= m_by && pyv < m_by + 8) return 3'b111;
    if (px >= 16 && px <= 23 && pyv >= m_py && pyv < m_py + 64) return 3'b010;
    if (px < 4 || px > 635 || pyv < 4 || pyv > 475) return 3'b001;
    if (m_state == 2) return 3'b100;
    return 3'b000;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick(input bit up, input bit dn);
    BTN_UP = up; BTN_DN = dn; x = 10'd0; blank = 1'b1; y = 10'd480;
    step();
    model_tick(up, dn, last_hit);
    y = 10'd0;
    step();
  endtask

  task automatic ticks(input int n, input bit up, input bit dn);
    for (int i = 0; i < n; i++) tick(up, dn);
  endtask

  task automatic probe_exp(input int px, input int pyv, input bit bl, input string tag,
                           input logic [2:0] exp);
    exp_t e;
    x = 10'(px); y = 10'(pyv); blank = bl;
    sbq.push_back('{tag, exp});
    step();
    e = sbq.pop_front();
    checks++;
    assert ({R, G, B} === e.exp)
      else begin errors++; $error("FAIL %s rgb=%b expected=%b", e.tag, {R, G, B}, e.exp); end
  endtask

  task automatic probe(input int px, input int pyv, input bit bl, input string tag);
    probe_exp(px, pyv, bl, tag, model_pix(px, pyv, bl));
  endtask

  task automatic probe_ball(input string tag);
    probe(m_bx, m_by, 0, {tag, "_tl"});
    probe(m_bx + 7, m_by + 7, 0, {tag, "_br"});
    probe(m_bx - 1, m_by, 0, {tag, "_left_out"});
    probe(m_bx + 8, m_by + 7, 0, {tag, "_right_out"});
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input int exp);
    checks++;
    assert (obs === 4'(exp))
      else begin errors++; $error("FAIL %s got=%0d expected=%0d", tag, obs, exp); end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s timeout", tag);
  endtask

  initial begin
    int  budget, sat_done, prev_hits;
    bit  up, dn;

    RST_N = 1'b0; x = 10'd0; y = 10'd0; blank = 1'b0; BTN_UP = 1'b0; BTN_DN = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    assert ({R, G, B} === 3'b000)
      else begin errors++; $error("FAIL reset_rgb rgb=%b expected=000", {R, G, B}); end
    chk4("reset_hits", hits, 0);
    chk4("reset_misses", misses, 0);
    RST_N = 1'b1;
    step();

    probe_exp(316, 236, 0, "serve_ball", 3'b111);
    probe_exp(16, 208, 0, "pad_top", 3'b010);
    probe_exp(23, 271, 0, "pad_bot", 3'b010);
    probe_exp(16, 272, 0, "pad_below", 3'b000);
    probe_exp(0, 100, 0, "border_left", 3'b001);
    probe_exp(639, 479, 0, "border_corner", 3'b001);

    // Serve hold then first move: (316,236) -> (314,238)
    ticks(60, 0, 0);
    probe_exp(316, 236, 0, "serve_end_hold", 3'b111);
    tick(0, 0);
    probe_exp(314, 238, 0, "first_move_tl", 3'b111);
    probe_exp(321, 245, 0, "first_move_br", 3'b111);
    probe_exp(316, 236, 0, "first_move_old", 3'b000);
    probe_exp(322, 245, 0, "first_move_right", 3'b000);

    ticks(60, 1, 0);
    probe_exp(16, 4, 0, "pad_up_top", 3'b010);
    probe_exp(16, 67, 0, "pad_up_bot", 3'b010);
    probe_exp(16, 68, 0, "pad_up_below", 3'b000);
    ticks(3, 1, 1);
    probe_exp(16, 4, 0, "pad_both_hold", 3'b010);
    probe_exp(16, 68, 0, "pad_both_below", 3'b000);
    probe_ball("play_ball");

    // Paddle parked at the top: ball reaches the left edge far below it
    budget = 0;
    while (m_state != 2 && budget < 400) begin tick(1, 0); budget++; end
    if (m_state != 2) timeout("miss_wait");
    chk4("miss_count", misses, 1);
    chk4("miss_hits", hits, 0);
    probe_exp(320, 300, 0, "miss_bg", 3'b100);
    probe_ball("miss_ball");
    ticks(29, 0, 0);
    probe_exp(320, 300, 0, "miss_bg_late", 3'b100);
    tick(0, 0);
    probe_exp(320, 300, 0, "reserve_bg", 3'b000);
    probe_exp(316, 236, 0, "reserve_ball", 3'b111);

    // Paddle tracks the ball until hits saturate and one more hit lands
    budget = 0; sat_done = 0;
    while (!sat_done && budget < 15000) begin
      up = (m_py + 28 > m_by);
      dn = (m_py + 36 < m_by);
      prev_hits = m_hits;
      tick(up, dn);
      budget++;
      if (last_hit) begin
        chk4("hit_count", hits, m_hits);
        if (prev_hits == 15) begin
          chk4("hits_saturated", hits, 15);
          sat_done = 1;
        end
      end
      if (budget % 97 == 0) probe_ball("track_ball");
    end
    if (!sat_done) timeout("hit_saturation");
    chk4("track_misses", misses, m_misses);
    probe_ball("after_hits");
    probe_exp(m_bx, m_by, 1, "blank_on_ball", 3'b000);

    // y held at 480 for four clocks must give a single frame update
    up = (m_py > 100);
    BTN_UP = up; BTN_DN = !up; x = 10'd0; blank = 1'b1; y = 10'd480;
    repeat (4) step();
    model_tick(up, !up, last_hit);
    y = 10'd0;
    step();
    probe(16, m_py, 0, "hold480_pad_top");
    probe(16, m_py - 1, 0, "hold480_pad_above");
    probe(16, m_py + 64, 0, "hold480_pad_below");
    probe_ball("hold480_ball");

    // Steer the paddle away to force a miss, then reset in the middle of MISS
    budget = 0;
    while (m_state != 2 && budget < 2000) begin
      dn = (m_by + 4 < m_py + 32);
      tick(!dn, dn);
      budget++;
    end
    if (m_state != 2) timeout("miss2_wait");
    ticks(5, 0, 0);
    probe_exp(320, 300, 0, "miss2_bg", 3'b100);
    chk4("miss2_hits", hits, 15);
    RST_N = 1'b0;
    #2;
    checks++;
    assert ({R, G, B} === 3'b000)
      else begin errors++; $error("FAIL midmiss_reset_rgb rgb=%b expected=000", {R, G, B}); end
    chk4("midmiss_reset_hits", hits, 0);
    chk4("midmiss_reset_misses", misses, 0);
    step();
    RST_N = 1'b1;
    model_reset();
    x = 10'd320; y = 10'd300; blank = 1'b0;
    step();
    probe_exp(320, 300, 0, "post_reset_bg", 3'b000);
    probe_exp(16, 208, 0, "post_reset_pad", 3'b010);
    ticks(60, 0, 0);
    probe_exp(316, 236, 0, "post_reset_serve_end", 3'b111);
    tick(0, 0);
    probe_exp(314, 238, 0, "post_reset_first_move", 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
